// File: rtl/param_counter_pkg.sv
// Shared constants for the parameterised up/down counter.
// Mode and direction encodings are used by both the step logic and the top.
package param_counter_pkg;

    localparam logic MODE_WRAP     = 1'b0;
    localparam logic MODE_SATURATE = 1'b1;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/param_counter_next.sv
// Combinational step logic: next count and boundary flag for one enabled step,
// assuming the current count is already within 0..max.
module param_counter_next
    import param_counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] max,
    input  logic [WIDTH-1:0] step,
    input  logic             up,
    input  logic             mode,
    output logic [WIDTH-1:0] next_count,
    output logic             wrap
);

    logic [WIDTH:0] count_x;
    logic [WIDTH:0] max_x;
    logic [WIDTH:0] step_x;
    logic [WIDTH:0] limit;
    logic [WIDTH:0] step_eff;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] result;

    // One extra bit keeps max+1 and count+step from overflowing at full range.
    always_comb begin
        count_x  = {1'b0, count};
        max_x    = {1'b0, max};
        step_x   = {1'b0, step};
        limit    = max_x + {{WIDTH{1'b0}}, 1'b1};
        step_eff = (step_x < limit) ? step_x : limit;
        sum      = count_x + step_eff;
        result   = count_x;
        wrap     = 1'b0;

        if (step_eff == '0) begin
            result = count_x;
        end else if (up == DIR_UP) begin
            if (sum <= max_x) begin
                result = sum;
            end else begin
                wrap   = 1'b1;
                result = (mode == MODE_WRAP) ? (sum - limit) : max_x;
            end
        end else begin
            if (count_x >= step_eff) begin
                result = count_x - step_eff;
            end else begin
                wrap   = 1'b1;
                result = (mode == MODE_WRAP) ? (count_x + limit - step_eff) : '0;
            end
        end

        next_count = WIDTH'(result);
    end

endmodule

// File: rtl/param_counter.sv
// Registered up/down counter with runtime limit, step, wrap/saturate mode
// and synchronous load; the step arithmetic lives in param_counter_next.
module param_counter
    import param_counter_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int RESET_VALUE = 0
) (
    input  logic             _m_clk,
    input  logic             _m_rst,
    input  logic             _m_en,
    input  logic             _m_up,
    input  logic             _m_mode,
    input  logic [WIDTH-1:0] _m_max,
    input  logic [WIDTH-1:0] _m_step,
    input  logic             _m_load,
    input  logic [WIDTH-1:0] _m_load_value,
    output logic [WIDTH-1:0] __output,
    output logic             __output_wrap
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    logic [WIDTH-1:0] step_count;
    logic             step_wrap;

    param_counter_next #(
        .WIDTH(WIDTH)
    ) u_next (
        .count      (count_q),
        .max        (_m_max),
        .step       (_m_step),
        .up         (_m_up),
        .mode       (_m_mode),
        .next_count (step_count),
        .wrap       (step_wrap)
    );

    // Load beats out-of-range recovery, which beats a normal step; idle clears the flag.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (_m_load) begin
            count_d = (_m_load_value > _m_max) ? _m_max : _m_load_value;
        end else if (_m_en && (count_q > _m_max)) begin
            wrap_d  = 1'b1;
            count_d = ((_m_up == DIR_UP) && (_m_mode == MODE_WRAP)) ? '0 : _m_max;
        end else if (_m_en) begin
            count_d = step_count;
            wrap_d  = step_wrap;
        end
    end

    always_ff @(posedge _m_clk or posedge _m_rst) begin
        if (_m_rst) begin
            count_q <= WIDTH'(RESET_VALUE);
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign __output      = count_q;
    assign __output_wrap = wrap_q;

endmodule

// File: tb/tb_param_counter.sv
// Directed-vector bench for param_counter (WIDTH=8, RESET_VALUE=0).
// Inputs change on the falling edge; outputs are checked on the following falling edge.
module tb_param_counter;
    import param_counter_pkg::*;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       up;
    logic       mode;
    logic [7:0] maxValue;
    logic [7:0] step;
    logic       load;
    logic [7:0] loadValue;
    logic [7:0] countOut;
    logic       wrapOut;

    int vectorCount;
    int miscompareCount;

    param_counter #(
        .WIDTH       (8),
        .RESET_VALUE (0)
    ) dut (
        ._m_clk        (clock),
        ._m_rst        (reset),
        ._m_en         (enable),
        ._m_up         (up),
        ._m_mode       (mode),
        ._m_max        (maxValue),
        ._m_step       (step),
        ._m_load       (load),
        ._m_load_value (loadValue),
        .__output      (countOut),
        .__output_wrap (wrapOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectorCount++;
        if (observed !== expected) begin
            miscompareCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic dirUp, input logic md,
                                 input int mx, input int st,
                                 input logic ld, input int ldValue);
        enable    = en;
        up        = dirUp;
        mode      = md;
        maxValue  = 8'(mx);
        step      = 8'(st);
        load      = ld;
        loadValue = 8'(ldValue);
    endtask

    // One clock edge, then compare both outputs at the next falling edge.
    task automatic stepAndCheck(input string tag, input int expCount, input int expWrap);
        @(posedge clock);
        @(negedge clock);
        checkOutput({tag, ".count"}, int'(countOut), expCount);
        checkOutput({tag, ".wrap"}, int'(wrapOut), expWrap);
    endtask

    initial begin
        vectorCount     = 0;
        miscompareCount = 0;

        // Load and enable are asserted while reset is held; neither may take effect.
        reset = 1'b1;
        applyStimulus(1'b1, DIR_UP, MODE_WRAP, 2, 1, 1'b1, 55);
        @(negedge clock);
        @(negedge clock);
        checkOutput("reset.count", int'(countOut), 0);
        checkOutput("reset.wrap", int'(wrapOut), 0);

        applyStimulus(1'b1, DIR_UP, MODE_WRAP, 2, 1, 1'b0, 0);
        reset = 1'b0;
        stepAndCheck("max2.a", 1, 0);
        stepAndCheck("max2.b", 2, 0);
        stepAndCheck("max2.c", 0, 1);

        // max=9 step=4 up wrap: 8+4=12 wraps to 12-10=2, 6+4=10 wraps to 0.
        applyStimulus(1'b1, DIR_UP, MODE_WRAP, 9, 4, 1'b1, 0);
        stepAndCheck("wrapUp.load", 0, 0);
        applyStimulus(1'b1, DIR_UP, MODE_WRAP, 9, 4, 1'b0, 0);
        stepAndCheck("wrapUp.a", 4, 0);
        stepAndCheck("wrapUp.b", 8, 0);
        stepAndCheck("wrapUp.c", 2, 1);
        stepAndCheck("wrapUp.d", 6, 0);
        stepAndCheck("wrapUp.e", 0, 1);

        applyStimulus(1'b1, DIR_DOWN, MODE_SATURATE, 9, 4, 1'b1, 5);
        stepAndCheck("satDown.load", 5, 0);
        applyStimulus(1'b1, DIR_DOWN, MODE_SATURATE, 9, 4, 1'b0, 0);
        stepAndCheck("satDown.a", 1, 0);
        stepAndCheck("satDown.b", 0, 1);
        stepAndCheck("satDown.c", 0, 1);

        // Limit lowered below the current count.
        applyStimulus(1'b0, DIR_UP, MODE_WRAP, 9, 1, 1'b1, 7);
        stepAndCheck("oorWrap.load", 7, 0);
        applyStimulus(1'b1, DIR_UP, MODE_WRAP, 3, 1, 1'b0, 0);
        stepAndCheck("oorWrap", 0, 1);
        applyStimulus(1'b0, DIR_UP, MODE_WRAP, 9, 1, 1'b1, 7);
        stepAndCheck("oorSat.load", 7, 0);
        applyStimulus(1'b1, DIR_UP, MODE_SATURATE, 3, 1, 1'b0, 0);
        stepAndCheck("oorSat", 3, 1);
        stepAndCheck("satHold.a", 3, 1);
        stepAndCheck("satHold.b", 3, 1);
        applyStimulus(1'b0, DIR_UP, MODE_WRAP, 9, 1, 1'b1, 8);
        stepAndCheck("oorDown.load", 8, 0);
        applyStimulus(1'b1, DIR_DOWN, MODE_WRAP, 5, 1, 1'b0, 0);
        stepAndCheck("oorDown", 5, 1);

        // Disabled: count holds and the flag drops.
        applyStimulus(1'b0, DIR_UP, MODE_WRAP, 5, 1, 1'b0, 0);
        stepAndCheck("idle", 5, 0);

        applyStimulus(1'b1, DIR_UP, MODE_WRAP, 5, 0, 1'b0, 0);
        stepAndCheck("stepZero", 5, 0);

        // Down wrap: 1+10-4 = 7.
        applyStimulus(1'b1, DIR_DOWN, MODE_WRAP, 9, 4, 1'b1, 1);
        stepAndCheck("wrapDown.load", 1, 0);
        applyStimulus(1'b1, DIR_DOWN, MODE_WRAP, 9, 4, 1'b0, 0);
        stepAndCheck("wrapDown", 7, 1);

        // Oversized step clamps to max+1=4, so 1 stays at 1 after a wrap.
        applyStimulus(1'b1, DIR_UP, MODE_WRAP, 3, 200, 1'b1, 1);
        stepAndCheck("bigStep.load", 1, 0);
        applyStimulus(1'b1, DIR_UP, MODE_WRAP, 3, 200, 1'b0, 0);
        stepAndCheck("bigStep", 1, 1);

        // Full-range wrap needs the extra bit: 250+10 = 260 -> 4.
        applyStimulus(1'b1, DIR_UP, MODE_WRAP, 255, 10, 1'b1, 250);
        stepAndCheck("fullRange.load", 250, 0);
        applyStimulus(1'b1, DIR_UP, MODE_WRAP, 255, 10, 1'b0, 0);
        stepAndCheck("fullRange", 4, 1);

        applyStimulus(1'b1, DIR_UP, MODE_WRAP, 0, 3, 1'b1, 9);
        stepAndCheck("maxZero.load", 0, 0);
        applyStimulus(1'b1, DIR_UP, MODE_WRAP, 0, 3, 1'b0, 0);
        stepAndCheck("maxZero.wrapUp", 0, 1);
        applyStimulus(1'b1, DIR_DOWN, MODE_SATURATE, 0, 1, 1'b0, 0);
        stepAndCheck("maxZero.satDown", 0, 1);

        // Load clamps to max and wins over enable.
        applyStimulus(1'b1, DIR_UP, MODE_WRAP, 100, 5, 1'b1, 200);
        stepAndCheck("loadClamp", 100, 0);

        // Asynchronous reset pulse between edges.
        applyStimulus(1'b1, DIR_UP, MODE_WRAP, 100, 5, 1'b0, 0);
        #1 reset = 1'b1;
        #1;
        checkOutput("asyncReset.count", int'(countOut), 0);
        checkOutput("asyncReset.wrap", int'(wrapOut), 0);
        #1 reset = 1'b0;
        stepAndCheck("afterReset", 5, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
